// File: rtl/pkt_rx_buffered.sv
// Packet receiver with per-VC flit FIFOs, pop-driven credit return and a per-VC packet checker.
// Optional build macro PKT_RX_SEQ_CHECK_EN stores payloads and checks B/T sequence numbers.
module pkt_rx_buffered #(
  parameter int NUM_VCS   = 2,
  parameter int BUF_DEPTH = 4,
  parameter int PAYLOAD_W = 16,
  localparam int VC_W     = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [2:0]           flit_type_i,
  input  logic [VC_W-1:0]      flit_vcid_i,
  input  logic [PAYLOAD_W-1:0] flit_payload_i,
  input  logic [NUM_VCS-1:0]   drain_en_i,
  output logic [NUM_VCS-1:0]   credits_o,
  output logic [NUM_VCS-1:0]   pkt_done_o,
  output logic                 err_o,
  output logic [15:0]          err_cnt_o,
  output logic [31:0]          pkt_cnt_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUF_DEPTH);
  localparam logic [VC_W:0]    NUM_VCS_V = (VC_W+1)'(NUM_VCS);
  localparam logic [2:0] TYPE_H  = 3'd1;
  localparam logic [2:0] TYPE_B  = 3'd2;
  localparam logic [2:0] TYPE_T  = 3'd3;
  localparam logic [2:0] TYPE_HT = 3'd4;
`ifdef PKT_RX_SEQ_CHECK_EN
  localparam int ENTRY_W = 3 + PAYLOAD_W;
`else
  localparam int ENTRY_W = 3;
`endif

  typedef enum logic {ST_IDLE = 1'b0, ST_IN_PKT = 1'b1} vc_state_t;

  logic [ENTRY_W-1:0]   mem_r      [NUM_VCS][BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r   [NUM_VCS];
  logic [PTR_W-1:0]     rd_ptr_r   [NUM_VCS];
  logic [CNT_W-1:0]     cnt_r      [NUM_VCS];
  logic [ENTRY_W-1:0]   head_s     [NUM_VCS];
  logic [ENTRY_W-1:0]   entry_s;
  logic [2:0]           pop_type_r [NUM_VCS];
  vc_state_t            state_r    [NUM_VCS];
  vc_state_t            state_nxt_s[NUM_VCS];
  logic [PAYLOAD_W-1:0] exp_r      [NUM_VCS];
  logic [PAYLOAD_W-1:0] exp_nxt_s  [NUM_VCS];
`ifdef PKT_RX_SEQ_CHECK_EN
  logic [PAYLOAD_W-1:0] pop_pl_r   [NUM_VCS];
`else
  logic                 unused_payload_s;
`endif

  logic [NUM_VCS-1:0] push_s, accept_s, drop_s, pop_s, pop_r;
  logic [NUM_VCS-1:0] done_s, proto_err_s, seq_err_s, seq_miss_s;
  logic               flit_valid_s, bad_vcid_s;
  logic [4:0]         err_sum_s;
  logic [3:0]         done_sum_s;
  logic [16:0]        err_cnt_sum_s;
  logic [15:0]        err_cnt_nxt_s;

  logic [NUM_VCS-1:0] credits_r, done_r;
  logic               err_r;
  logic [15:0]        err_cnt_r;
  logic [31:0]        pkt_cnt_r;

`ifdef PKT_RX_SEQ_CHECK_EN
  assign entry_s = {flit_payload_i, flit_type_i};
`else
  assign entry_s = flit_type_i;
  assign unused_payload_s = ^flit_payload_i;
`endif

  // Flit decode and per-VC push/pop/drop decisions
  always_comb begin
    flit_valid_s = 1'b0;
    case (flit_type_i)
      TYPE_H, TYPE_B, TYPE_T, TYPE_HT: flit_valid_s = 1'b1;
      default:                         flit_valid_s = 1'b0;
    endcase
    bad_vcid_s = flit_valid_s && ({1'b0, flit_vcid_i} >= NUM_VCS_V);
    for (int v = 0; v < NUM_VCS; v++) begin
      head_s[v]   = mem_r[v][rd_ptr_r[v]];
      push_s[v]   = flit_valid_s && ({1'b0, flit_vcid_i} == (VC_W+1)'(v));
      pop_s[v]    = drain_en_i[v] && (cnt_r[v] != {CNT_W{1'b0}});
      // a same-cycle pop frees the slot a push into a full FIFO needs
      accept_s[v] = push_s[v] && ((cnt_r[v] != FULL_CNT) || pop_s[v]);
      drop_s[v]   = push_s[v] && (cnt_r[v] == FULL_CNT) && !pop_s[v];
    end
  end

  // FIFO storage (no reset needed, occupancy is tracked by the pointers)
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (accept_s[v]) begin
        mem_r[v][wr_ptr_r[v]] <= entry_s;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        wr_ptr_r[v] <= {PTR_W{1'b0}};
        rd_ptr_r[v] <= {PTR_W{1'b0}};
        cnt_r[v]    <= {CNT_W{1'b0}};
      end
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (accept_s[v]) wr_ptr_r[v] <= wr_ptr_r[v] + PTR_W'(1);
        if (pop_s[v])    rd_ptr_r[v] <= rd_ptr_r[v] + PTR_W'(1);
        cnt_r[v] <= cnt_r[v] + CNT_W'(accept_s[v]) - CNT_W'(pop_s[v]);
      end
    end
  end

  // Popped-flit stage feeding the checkers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pop_r <= {NUM_VCS{1'b0}};
      for (int v = 0; v < NUM_VCS; v++) begin
        pop_type_r[v] <= 3'd0;
`ifdef PKT_RX_SEQ_CHECK_EN
        pop_pl_r[v]   <= {PAYLOAD_W{1'b0}};
`endif
      end
    end else begin
      pop_r <= pop_s;
      for (int v = 0; v < NUM_VCS; v++) begin
        pop_type_r[v] <= head_s[v][2:0];
`ifdef PKT_RX_SEQ_CHECK_EN
        pop_pl_r[v]   <= head_s[v][ENTRY_W-1:3];
`endif
      end
    end
  end

  // Checker next-state: packet framing and sequence tracking per VC
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      state_nxt_s[v] = state_r[v];
      exp_nxt_s[v]   = exp_r[v];
      done_s[v]      = 1'b0;
      proto_err_s[v] = 1'b0;
      seq_err_s[v]   = 1'b0;
`ifdef PKT_RX_SEQ_CHECK_EN
      seq_miss_s[v]  = (pop_pl_r[v] != exp_r[v]);
`else
      seq_miss_s[v]  = 1'b0;
`endif
      if (pop_r[v]) begin
        case (state_r[v])
          ST_IDLE: begin
            case (pop_type_r[v])
              TYPE_H:         begin state_nxt_s[v] = ST_IN_PKT; exp_nxt_s[v] = PAYLOAD_W'(1); end
              TYPE_HT:        done_s[v] = 1'b1;
              TYPE_B, TYPE_T: proto_err_s[v] = 1'b1;
              default:        state_nxt_s[v] = ST_IDLE;
            endcase
          end
          ST_IN_PKT: begin
            case (pop_type_r[v])
              TYPE_B: begin
                exp_nxt_s[v] = exp_r[v] + PAYLOAD_W'(1);
                seq_err_s[v] = seq_miss_s[v];
              end
              TYPE_T: begin
                state_nxt_s[v] = ST_IDLE;
                done_s[v]      = 1'b1;
                seq_err_s[v]   = seq_miss_s[v];
              end
              TYPE_H: begin
                proto_err_s[v] = 1'b1;
                exp_nxt_s[v]   = PAYLOAD_W'(1);
              end
              TYPE_HT: begin
                proto_err_s[v] = 1'b1;
                done_s[v]      = 1'b1;
                state_nxt_s[v] = ST_IDLE;
              end
              default: state_nxt_s[v] = ST_IN_PKT;
            endcase
          end
          default: state_nxt_s[v] = ST_IDLE;
        endcase
      end else begin
        state_nxt_s[v] = state_r[v];
      end
    end
  end

  // Checker state register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        state_r[v] <= ST_IDLE;
        exp_r[v]   <= {PAYLOAD_W{1'b0}};
      end
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        state_r[v] <= state_nxt_s[v];
        exp_r[v]   <= exp_nxt_s[v];
      end
    end
  end

  // Per-cycle error and completion totals
  always_comb begin
    err_sum_s  = {4'd0, bad_vcid_s};
    done_sum_s = 4'd0;
    for (int v = 0; v < NUM_VCS; v++) begin
      err_sum_s  = err_sum_s + 5'(drop_s[v]) + 5'(proto_err_s[v]) + 5'(seq_err_s[v]);
      done_sum_s = done_sum_s + 4'(done_s[v]);
    end
    err_cnt_sum_s = {1'b0, err_cnt_r} + 17'(err_sum_s);
    err_cnt_nxt_s = err_cnt_sum_s[16] ? 16'hFFFF : err_cnt_sum_s[15:0];
  end

  // Registered status outputs
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      credits_r <= {NUM_VCS{1'b0}};
      done_r    <= {NUM_VCS{1'b0}};
      err_r     <= 1'b0;
      err_cnt_r <= 16'd0;
      pkt_cnt_r <= 32'd0;
    end else begin
      credits_r <= pop_s;
      done_r    <= done_s;
      err_r     <= err_r | (err_sum_s != 5'd0);
      err_cnt_r <= err_cnt_nxt_s;
      pkt_cnt_r <= pkt_cnt_r + 32'(done_sum_s);
    end
  end

  assign credits_o  = credits_r;
  assign pkt_done_o = done_r;
  assign err_o      = err_r;
  assign err_cnt_o  = err_cnt_r;
  assign pkt_cnt_o  = pkt_cnt_r;

endmodule

// File: doc/pkt_rx_buffered.md
PKT_RX_BUFFERED -- requirements
Module: pkt_rx_buffered

Interface
REQ-001 SHALL have parameter NUM_VCS, default 2, number of virtual channels (1..8).
REQ-002 SHALL have parameter BUF_DEPTH, default 4, per-VC flit buffer depth (power of two, 2..16).
REQ-003 SHALL have parameter PAYLOAD_W, default 16, payload field width; VC_W = max(1, clog2(NUM_VCS)) is derived.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port arst  input  1  asynchronous reset, active-high.
REQ-006 SHALL have port flit_type_i  input  3  flit type: I=0, H=1, B=2, T=3, HT=4; values 5..7 are treated as I.
REQ-007 SHALL have port flit_vcid_i  input  VC_W  VC of the incoming flit.
REQ-008 SHALL have port flit_payload_i  input  PAYLOAD_W  sequence payload.
REQ-009 SHALL have port drain_en_i  input  NUM_VCS  per-VC consumer ready.
REQ-010 SHALL have port credits_o  output  NUM_VCS  one-cycle credit pulse per VC.
REQ-011 SHALL have port pkt_done_o  output  NUM_VCS  one-cycle packet-complete pulse per VC.
REQ-012 SHALL have port err_o  output  1  sticky error flag.
REQ-013 SHALL have port err_cnt_o  output  16  saturating error count.
REQ-014 SHALL have port pkt_cnt_o  output  32  wrapping count of completed packets.

Function
REQ-015 Non-I flit with flit_vcid_i < NUM_VCS SHALL be pushed into FIFO[vcid] at that edge; vcid >= NUM_VCS SHALL count as one error and be dropped.
REQ-016 Push into a full FIFO with no same-cycle pop SHALL drop the flit and count one error; full FIFO with same-cycle pop SHALL accept the push.
REQ-017 When drain_en_i[v]=1 and FIFO[v] is non-empty, the head SHALL be popped that edge; a flit pushed at edge N SHALL be poppable no earlier than edge N+1.
REQ-018 A pop on VC v at edge M SHALL drive credits_o[v]=1 for exactly the cycle after edge M; credits SHALL be generated only on pop, never on arrival or drop.
REQ-019 Each VC SHALL run a checker FSM on popped flits, states IDLE and IN_PKT, with an expected-payload register of PAYLOAD_W bits.
REQ-020 IDLE: H -> IN_PKT, expected := 1; HT -> stays IDLE, pkt_done pulse; B or T -> error, stays IDLE.
REQ-021 IN_PKT: B -> expected += 1 (wraps modulo 2^PAYLOAD_W); T -> IDLE, pkt_done pulse; H -> error, restart with expected := 1; HT -> error, pkt_done pulse, IDLE.
REQ-022 pkt_done_o[v] and pkt_cnt_o SHALL update at the edge following the completing pop; pkt_cnt_o SHALL add the number of VCs completing in the same cycle, wrapping at 2^32.
REQ-023 err_cnt_o SHALL add all errors detected in one cycle (drop, bad vcid, protocol, payload), saturating at 0xFFFF; err_o SHALL set on the first error and hold until reset.
REQ-024 VCs SHALL be fully independent; simultaneous push on one VC and pops on any VCs SHALL all be honoured in one cycle.

Reset
REQ-025 While arst=1: all FIFOs empty, all FSMs IDLE, expected=0, credits_o=0, pkt_done_o=0, err_o=0, err_cnt_o=0, pkt_cnt_o=0.
REQ-026 Reset asserted mid-packet SHALL discard buffered flits without issuing credits; the first flit after release SHALL be checked from IDLE.

Configuration
REQ-027 With macro PKT_RX_SEQ_CHECK_EN defined, B/T popped in IN_PKT SHALL be checked for payload == expected, and a mismatch SHALL count one error while the FSM transitions as in REQ-021.
REQ-028 Without PKT_RX_SEQ_CHECK_EN, payload SHALL NOT be checked and SHALL NOT be stored in the FIFO (FIFO width is the 3-bit type only); all other behaviour is unchanged.

Verification
REQ-029 VC0 H(0),B(1),B(2),T(3) with drain_en_i=2'b01 -> four credits_o[0] pulses, one pkt_done_o[0], pkt_cnt_o=1, err_cnt_o=0.
REQ-030 drain_en_i=0, five flits pushed into VC1 (BUF_DEPTH=4) -> fifth dropped, err_cnt_o=1, err_o=1; after draining exactly 4 credits_o[1] pulses.
REQ-031 Full VC0 FIFO, push and pop in the same cycle -> no error, occupancy remains 4, one credit pulse.
REQ-032 PKT_RX_SEQ_CHECK_EN defined, VC0 H(0),B(1),B(5),T(3) -> err_cnt_o=1, pkt_done_o[0] pulses once; without the macro -> err_cnt_o=0.
REQ-033 HT on VC0 and T completing on VC1, popped in the same cycle -> pkt_done_o=2'b11, pkt_cnt_o increments by 2.
REQ-034 arst pulsed after H,B buffered on VC0 -> no credits issued, outputs 0; a subsequent B on VC0 -> protocol error, err_cnt_o=1.
